// File: rtl/decomp_sequencer_if.sv
// Bus bundle between the decompression sequencer, the CPU fetch port,
// compressed program memory and the token table.
interface decomp_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int TBL_AW = 7
);
  logic              cpu_req;
  logic [WIDTH-1:0]  cpu_pc;
  logic              instr_valid;
  logic [WIDTH-1:0]  instr_out;
  logic              fetch_req;
  logic [WIDTH-1:0]  fetch_addr;
  logic              fetch_ack;
  logic [WIDTH-1:0]  fetch_data;
  logic [TBL_AW-1:0] tbl_addr;
  logic [WIDTH-1:0]  tbl_data;
  logic              bad_token;
  logic              busy;

  // CPU, memory and table side
  modport master (
    output cpu_req, cpu_pc, fetch_ack, fetch_data, tbl_data,
    input  instr_valid, instr_out, fetch_req, fetch_addr, tbl_addr, bad_token, busy
  );

  // Sequencer side
  modport slave (
    input  cpu_req, cpu_pc, fetch_ack, fetch_data, tbl_data,
    output instr_valid, instr_out, fetch_req, fetch_addr, tbl_addr, bad_token, busy
  );
endinterface

// File: rtl/decomp_sequencer.sv
// Control FSM for the instruction decompressor: tracks CPU PC vs compressed PC,
// fetches compressed words and expands escape tokens into two table entries.
module decomp_sequencer #(
  parameter int                 WIDTH    = 32,
  parameter int                 PC_INC   = 4,
  parameter int                 OP_BITS  = 4,
  parameter logic [OP_BITS-1:0] OPCODE   = 4'b1111,
  parameter int                 TBL_AW   = 7,
  parameter int                 TBL_SIZE = 102
) (
  input logic                clk,
  input logic                reset,
  decomp_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_TBL_A = 3'd2;
  localparam logic [2:0] S_TBL_B = 3'd3;
  localparam logic [2:0] S_TBL_C = 3'd4;

  // Last index whose pair (idx, idx+1) is still inside the table
  localparam logic [TBL_AW-1:0] IDX_MAX = TBL_AW'(TBL_SIZE - 2);

  logic [2:0]       state;
  logic [WIDTH-1:0] exp_pc;
  logic [WIDTH-1:0] cmp_pc;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;

  logic [TBL_AW-1:0] idx;
  logic              is_token;
  logic              idx_ok;

  function automatic logic [WIDTH-1:0] pc_next(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(PC_INC);
  endfunction

  always_comb begin
    idx      = bus.fetch_data[TBL_AW-1:0];
    is_token = (bus.fetch_data[WIDTH-1 -: OP_BITS] == OPCODE);
    idx_ok   = (idx <= IDX_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.fetch_req   <= 1'b0;
      bus.fetch_addr  <= '0;
      bus.tbl_addr    <= '0;
      bus.bad_token   <= 1'b0;
      bus.busy        <= 1'b0;
      exp_pc          <= '0;
      cmp_pc          <= '0;
      hold            <= '0;
      hold_valid      <= 1'b0;
    end else begin
      bus.instr_valid <= 1'b0;
      bus.bad_token   <= 1'b0;
      case (state)
        S_IDLE: begin
          // The delivery cycle itself consumes the request, so skip sampling then
          if (bus.cpu_req && !bus.instr_valid) begin
            if (bus.cpu_pc != exp_pc) begin
              hold_valid     <= 1'b0;
              exp_pc         <= bus.cpu_pc;
              cmp_pc         <= bus.cpu_pc;
              bus.fetch_addr <= bus.cpu_pc;
              bus.fetch_req  <= 1'b1;
              bus.busy       <= 1'b1;
              state          <= S_FETCH;
            end else if (hold_valid) begin
              bus.instr_out   <= hold;
              bus.instr_valid <= 1'b1;
              hold_valid      <= 1'b0;
              exp_pc          <= pc_next(exp_pc);
            end else begin
              bus.fetch_addr <= cmp_pc;
              bus.fetch_req  <= 1'b1;
              bus.busy       <= 1'b1;
              state          <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.fetch_ack) begin
            bus.fetch_req <= 1'b0;
            if (is_token && idx_ok) begin
              bus.tbl_addr <= idx;
              state        <= S_TBL_A;
            end else begin
              // Raw word, or a token pointing outside the table passed through as raw
              bus.instr_out   <= bus.fetch_data;
              bus.instr_valid <= 1'b1;
              bus.bad_token   <= is_token;
              exp_pc          <= pc_next(exp_pc);
              cmp_pc          <= pc_next(cmp_pc);
              bus.busy        <= 1'b0;
              state           <= S_IDLE;
            end
          end
        end
        S_TBL_A: begin
          bus.tbl_addr <= bus.tbl_addr + TBL_AW'(1);
          state        <= S_TBL_B;
        end
        S_TBL_B: begin
          bus.instr_out   <= bus.tbl_data;
          bus.instr_valid <= 1'b1;
          exp_pc          <= pc_next(exp_pc);
          state           <= S_TBL_C;
        end
        S_TBL_C: begin
          // Second expansion word is parked for the next sequential request
          hold       <= bus.tbl_data;
          hold_valid <= 1'b1;
          cmp_pc     <= pc_next(cmp_pc);
          bus.busy   <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          bus.fetch_req <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decomp_sequencer.sv
// Directed bench for decomp_sequencer: vector table of CPU requests plus
// hand-written stall and mid-expansion reset sequences.
module tb_decomp_sequencer;

  logic clk;
  logic reset;

  decomp_sequencer_if #(.WIDTH(32), .TBL_AW(7)) bus ();

  decomp_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] tbl [128];
  int          ack_delay = 0;
  int          ack_cnt   = 0;
  int          fetch_cnt = 0;
  logic [31:0] last_faddr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Registered token table, one-cycle read latency
  always @(posedge clk) bus.tbl_data <= tbl[bus.tbl_addr];

  // Compressed memory responder: acks after ack_delay cycles of fetch_req
  always @(negedge clk) begin
    if (reset) begin
      bus.fetch_ack = 1'b0;
      ack_cnt = 0;
    end else if (bus.fetch_ack) begin
      bus.fetch_ack = 1'b0;
      ack_cnt = 0;
    end else if (bus.fetch_req) begin
      if (ack_cnt >= ack_delay) begin
        bus.fetch_ack  = 1'b1;
        bus.fetch_data = mem_rd(bus.fetch_addr);
        last_faddr     = bus.fetch_addr;
        fetch_cnt++;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request; returns delivered word, bad flag, latency, fetches and
  // the table addresses seen two and three cycles after the request.
  task automatic do_req(input logic [31:0] pc, output logic [31:0] instr, output logic bad,
                        output int lat, output int nf, output logic [6:0] ta2,
                        output logic [6:0] ta3);
    int f0;
    f0 = fetch_cnt;
    lat = -1;
    instr = '0;
    bad = 1'b0;
    ta2 = '0;
    ta3 = '0;
    bus.cpu_req = 1'b1;
    bus.cpu_pc  = pc;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 2) ta2 = bus.tbl_addr;
      if (k == 3) ta3 = bus.tbl_addr;
      if (bus.instr_valid) begin
        instr = bus.instr_out;
        bad   = bus.bad_token;
        lat   = k;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    nf = fetch_cnt - f0;
    if (lat < 0) $display("FAIL timeout: no instr_valid for pc 0x%08h", pc);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] mword;
    logic [31:0] instr;
    logic        bad;
    int          lat;
    int          nf;
    logic [31:0] faddr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] instr;
    logic        bad;
    int          lat;
    int          nf;
    logic [6:0]  ta2;
    logic [6:0]  ta3;
    logic        saw_bad;

    for (int i = 0; i < 128; i++) tbl[i] = 32'hDEAD0000 | i;
    tbl[5]   = 32'hAAAA0001;
    tbl[6]   = 32'hBBBB0002;
    tbl[7]   = 32'hCCCC0003;
    tbl[8]   = 32'hDDDD0004;
    tbl[100] = 32'h64646464;
    tbl[101] = 32'h65656565;

    //            pc            mem word      instr         bad  lat nf faddr
    vecs[0]  = '{32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 2, 1, 32'h00000000};
    vecs[1]  = '{32'h00000004, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0, 2, 1, 32'h00000004};
    vecs[2]  = '{32'h00000100, 32'hF0000005, 32'hAAAA0001, 1'b0, 4, 1, 32'h00000100};
    vecs[3]  = '{32'h00000104, 32'h00000000, 32'hBBBB0002, 1'b0, 1, 0, 32'h00000000};
    vecs[4]  = '{32'h00000108, 32'h00001111, 32'h00001111, 1'b0, 2, 1, 32'h00000104};
    vecs[5]  = '{32'h0000010C, 32'hF0000007, 32'hCCCC0003, 1'b0, 4, 1, 32'h00000108};
    vecs[6]  = '{32'h00000040, 32'h40404040, 32'h40404040, 1'b0, 2, 1, 32'h00000040};
    vecs[7]  = '{32'h00000044, 32'hF000007F, 32'hF000007F, 1'b1, 2, 1, 32'h00000044};
    vecs[8]  = '{32'h00000048, 32'hF0000064, 32'h64646464, 1'b0, 4, 1, 32'h00000048};
    vecs[9]  = '{32'h0000004C, 32'h00000000, 32'h65656565, 1'b0, 1, 0, 32'h00000000};
    vecs[10] = '{32'h00000050, 32'hF0000065, 32'hF0000065, 1'b1, 2, 1, 32'h0000004C};
    vecs[11] = '{32'hFFFFFFFC, 32'hF0000005, 32'hAAAA0001, 1'b0, 4, 1, 32'hFFFFFFFC};
    vecs[12] = '{32'h00000000, 32'h00000000, 32'hBBBB0002, 1'b0, 1, 0, 32'h00000000};
    vecs[13] = '{32'h00000004, 32'h12345678, 32'h12345678, 1'b0, 2, 1, 32'h00000000};

    reset          = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_pc     = '0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = '0;
    do_reset();

    @(negedge clk);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_instr_out", bus.instr_out, 32'h0);
    chk("rst_fetch_req", {31'b0, bus.fetch_req}, 32'h0);
    chk("rst_fetch_addr", bus.fetch_addr, 32'h0);
    chk("rst_tbl_addr", {25'b0, bus.tbl_addr}, 32'h0);
    chk("rst_bad_token", {31'b0, bus.bad_token}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].nf > 0) mem[vecs[i].faddr] = vecs[i].mword;
      do_req(vecs[i].pc, instr, bad, lat, nf, ta2, ta3);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].instr);
      chk($sformatf("v%0d_bad", i), {31'b0, bad}, {31'b0, vecs[i].bad});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_fetches", i), nf, vecs[i].nf);
      if (vecs[i].nf > 0) chk($sformatf("v%0d_faddr", i), last_faddr, vecs[i].faddr);
      @(negedge clk);
    end

    // Fetch stall: exp_pc=8, cmp_pc=4 after the table, so addr 4 is fetched
    ack_delay = 5;
    bus.cpu_req = 1'b1;
    bus.cpu_pc  = 32'h8;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("stall%0d_fetch_req", k), {31'b0, bus.fetch_req}, 32'h1);
      chk($sformatf("stall%0d_fetch_addr", k), bus.fetch_addr, 32'h4);
      chk($sformatf("stall%0d_busy", k), {31'b0, bus.busy}, 32'h1);
      chk($sformatf("stall%0d_no_valid", k), {31'b0, bus.instr_valid}, 32'h0);
      @(negedge clk);
    end
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus.instr_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    bus.cpu_req = 1'b0;
    chk("stall_delivered", {31'b0, lat >= 0}, 32'h1);
    chk("stall_instr", bus.instr_out, 32'h9ABCDEF0);
    chk("stall_busy_after", {31'b0, bus.busy}, 32'h0);
    ack_delay = 0;

    // Token expansion from reset, with table address sequence
    do_reset();
    mem[32'h0] = 32'hF0000005;
    do_req(32'h0, instr, bad, lat, nf, ta2, ta3);
    chk("tok_tbl_addr_a", {25'b0, ta2}, 32'd5);
    chk("tok_tbl_addr_b", {25'b0, ta3}, 32'd6);
    chk("tok_instr", instr, 32'hAAAA0001);
    chk("tok_latency", lat, 32'd4);
    @(negedge clk);
    do_req(32'h4, instr, bad, lat, nf, ta2, ta3);
    chk("tok_hold_instr", instr, 32'hBBBB0002);
    chk("tok_hold_latency", lat, 32'd1);
    chk("tok_hold_no_fetch", nf, 32'd0);
    @(negedge clk);

    // Reset while in TBL_B: aborts the expansion, nothing delivered
    mem[32'h4] = 32'hF0000005;
    saw_bad = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_pc  = 32'h8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.instr_valid) saw_bad = 1'b1;
    end
    chk("tblb_no_early_valid", {31'b0, saw_bad}, 32'h0);
    chk("tblb_fetch_addr_pre", bus.fetch_addr, 32'h4);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("tblb_rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("tblb_rst_instr_out", bus.instr_out, 32'h0);
    chk("tblb_rst_fetch_req", {31'b0, bus.fetch_req}, 32'h0);
    chk("tblb_rst_fetch_addr", bus.fetch_addr, 32'h0);
    chk("tblb_rst_tbl_addr", {25'b0, bus.tbl_addr}, 32'h0);
    chk("tblb_rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("tblb_rst_hold_valid", {31'b0, dut.hold_valid}, 32'h0);
    do_req(32'h0, instr, bad, lat, nf, ta2, ta3);
    chk("tblb_refetch_addr", last_faddr, 32'h0);
    chk("tblb_refetch_count", nf, 32'd1);
    chk("tblb_refetch_instr", instr, 32'hAAAA0001);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
